// File: rtl/bottle_line_pkg.sv
// ----------------------------------------------------------------------------
// bottle_line_pkg
// Shared definitions for the bottling-line controller.
// Contents:
//   - FSM state type and codes (IDLE, REFILL)
//   - active-low 7-segment patterns (seg[0]=a .. seg[6]=g) for 0..9 and blank
//   - display slot indices
//   - bcd_to_seg : BCD digit -> active-low segment pattern
//   - bin_to_bcd : binary 0..99 -> two BCD digits {tens, units}
// ----------------------------------------------------------------------------
package bottle_line_pkg;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE   = 1'b0;
   localparam state_t ST_REFILL = 1'b1;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [1:0] SLOT_PACK_TENS  = 2'd0;
   localparam logic [1:0] SLOT_PACK_UNITS = 2'd1;
   localparam logic [1:0] SLOT_CORK_TENS  = 2'd2;
   localparam logic [1:0] SLOT_CORK_UNITS = 2'd3;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Stock never exceeds 99, so a flat match over all 100 codes is enough.
   function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
      logic [7:0] r;
      r = 8'h00;
      for (int t = 0; t < 10; t++) begin
         for (int u = 0; u < 10; u++) begin
            if (v == 7'(t * 10 + u)) begin
               r = {4'(t), 4'(u)};
            end else begin
               r = r;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bottle_line_ctrl_bcd_counter.sv
// ----------------------------------------------------------------------------
// bcd_counter
// Multi-digit decimal counter, digit 0 in the least significant nibble.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset (value -> 0)
//   inc   : add one this cycle
//   value : registered BCD count
//   wrap  : high in the cycle an increment rolls all-9s over to 0
// ----------------------------------------------------------------------------
module bcd_counter #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inc,
   output logic [4*DIGITS-1:0]   value,
   output logic                  wrap
);

   logic [4*DIGITS-1:0] value_q;
   logic [4*DIGITS-1:0] value_d;
   logic                carry_s;

   // Ripple the decimal carry from the least significant digit upward.
   always_comb begin
      value_d = value_q;
      carry_s = inc;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry_s) begin
            if (value_q[4*i +: 4] == 4'd9) begin
               value_d[4*i +: 4] = 4'd0;
            end else begin
               value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
               carry_s           = 1'b0;
            end
         end else begin
            value_d[4*i +: 4] = value_q[4*i +: 4];
         end
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_q <= {(4*DIGITS){1'b0}};
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign wrap  = carry_s;

endmodule

// File: rtl/bottle_line_ctrl.sv
// ----------------------------------------------------------------------------
// bottle_line_ctrl
// Bottling-line controller: pack counting, cork stock with timed refills,
// and a 4-digit multiplexed 7-segment display.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   bottle_pulse  : one bottle presented (1-cycle pulse)
//   pack_bcd      : pack count in BCD, digit 0 = LSD
//   cork_cnt      : cork stock (binary)
//   refills_left  : remaining refill credits
//   refill_busy   : refill sequence in progress
//   starved       : sticky, a bottle was rejected for lack of corks
//   pack_ovf      : sticky, pack counter wrapped from all-9s
//   seg, dig      : active-low segments (a..g = bit 0..6) and digit enables
// ----------------------------------------------------------------------------
module bottle_line_ctrl
   import bottle_line_pkg::*;
#(
   parameter int BOTTLES_PER_PACK = 12,
   parameter int PACK_DIGITS      = 2,
   parameter int CORK_MAX         = 25,
   parameter int CORK_LOW         = 5,
   parameter int REFILL_AMT       = 20,
   parameter int REFILL_CREDITS   = 7,
   parameter int REFILL_LAT       = 4,
   parameter int SCAN_DIV         = 8192
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      bottle_pulse,
   output logic [4*PACK_DIGITS-1:0]  pack_bcd,
   output logic [6:0]                cork_cnt,
   output logic [2:0]                refills_left,
   output logic                      refill_busy,
   output logic                      starved,
   output logic                      pack_ovf,
   output logic [6:0]                seg,
   output logic [3:0]                dig
);

   localparam int PW = $clog2(BOTTLES_PER_PACK);
   localparam int LW = (REFILL_LAT > 1) ? $clog2(REFILL_LAT) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(BOTTLES_PER_PACK - 1);
   localparam logic [LW-1:0] LAT_LOAD   = LW'(REFILL_LAT - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [6:0]    CORK_MAX_C = 7'(CORK_MAX);
   localparam logic [6:0]    CORK_LOW_C = 7'(CORK_LOW);
   localparam logic [7:0]    CORK_MAX_W = 8'(CORK_MAX);
   localparam logic [7:0]    REFILL_W   = 8'(REFILL_AMT);
   localparam logic [2:0]    CREDITS_C  = 3'(REFILL_CREDITS);
   // Slot 0 after reset shows pack tens, which is 0 or blank.
   localparam logic [6:0]    SEG_RST    = (PACK_DIGITS > 1) ? SEG_0 : SEG_BLANK;

   logic [PW-1:0] presc_q, presc_d;
   logic [6:0]    cork_q, cork_d;
   logic [2:0]    refills_q, refills_d;
   state_t        state_q, state_d;
   logic [LW-1:0] lat_q, lat_d;
   logic          busy_q, busy_d;
   logic          starved_q, starved_d;
   logic          ovf_q, ovf_d;
   logic [SW-1:0] scan_q, scan_d;
   logic [1:0]    slot_q, slot_d;
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    dig_q, dig_d;

   logic                     accept_s;
   logic                     reject_s;
   logic                     pack_inc_s;
   logic                     pack_wrap_s;
   logic [4*PACK_DIGITS-1:0] pack_val_s;
   logic [7:0]               cork_net_s;
   logic [7:0]               cork_sum_s;
   logic [7:0]               cork_bcd_s;
   logic [6:0]               pack_tens_seg_s;

   assign accept_s   = bottle_pulse && (cork_q != 7'd0);
   assign reject_s   = bottle_pulse && (cork_q == 7'd0);
   // 8-bit arithmetic so stock + refill can exceed the ceiling before clamping.
   assign cork_net_s = {1'b0, cork_q} - {7'd0, accept_s};
   assign cork_sum_s = cork_net_s + REFILL_W;
   assign cork_bcd_s = bin_to_bcd(cork_q);

   bcd_counter #(
      .DIGITS (PACK_DIGITS)
   ) u_pack_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pack_inc_s),
      .value (pack_val_s),
      .wrap  (pack_wrap_s)
   );

   generate
      if (PACK_DIGITS > 1) begin : g_pack_tens
         assign pack_tens_seg_s = bcd_to_seg(pack_val_s[7:4]);
      end else begin : g_pack_no_tens
         assign pack_tens_seg_s = SEG_BLANK;
      end
   endgenerate

   // Bottle prescaler: a pack is counted when it rolls back to 0.
   always_comb begin
      pack_inc_s = 1'b0;
      presc_d    = presc_q;
      if (accept_s) begin
         if (presc_q == PRESC_LAST) begin
            presc_d    = {PW{1'b0}};
            pack_inc_s = 1'b1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end else begin
         presc_d = presc_q;
      end
   end

   // Cork stock and refill sequencer.
   always_comb begin
      state_d   = state_q;
      lat_d     = lat_q;
      cork_d    = cork_net_s[6:0];
      refills_d = refills_q;
      starved_d = starved_q | reject_s;
      case (state_q)
         ST_IDLE: begin
            if ((cork_q <= CORK_LOW_C) && (refills_q != 3'd0)) begin
               state_d = ST_REFILL;
               lat_d   = LAT_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REFILL: begin
            if (lat_q == {LW{1'b0}}) begin
               // A bottle taken this same cycle is netted out before the top-up.
               cork_d    = (cork_sum_s > CORK_MAX_W) ? CORK_MAX_C : cork_sum_s[6:0];
               refills_d = refills_q - 3'd1;
               starved_d = 1'b0;
               state_d   = ST_IDLE;
            end else begin
               lat_d = lat_q - LW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_REFILL);
      ovf_d  = ovf_q | pack_wrap_s;
   end

   // Display scan: slot advances every SCAN_DIV cycles; seg/dig follow one cycle later.
   always_comb begin
      scan_d = (scan_q == SCAN_LAST) ? {SW{1'b0}} : scan_q + SW'(1);
      slot_d = (scan_q == SCAN_LAST) ? slot_q + 2'd1 : slot_q;
      case (slot_q)
         SLOT_PACK_TENS: begin
            seg_d = pack_tens_seg_s;
            dig_d = 4'b1110;
         end
         SLOT_PACK_UNITS: begin
            seg_d = bcd_to_seg(pack_val_s[3:0]);
            dig_d = 4'b1101;
         end
         SLOT_CORK_TENS: begin
            seg_d = bcd_to_seg(cork_bcd_s[7:4]);
            dig_d = 4'b1011;
         end
         SLOT_CORK_UNITS: begin
            seg_d = bcd_to_seg(cork_bcd_s[3:0]);
            dig_d = 4'b0111;
         end
         default: begin
            seg_d = SEG_BLANK;
            dig_d = 4'b1111;
         end
      endcase
   end

   // Controller state and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q   <= {PW{1'b0}};
         cork_q    <= CORK_MAX_C;
         refills_q <= CREDITS_C;
         state_q   <= ST_IDLE;
         lat_q     <= {LW{1'b0}};
         busy_q    <= 1'b0;
         starved_q <= 1'b0;
         ovf_q     <= 1'b0;
         scan_q    <= {SW{1'b0}};
         slot_q    <= SLOT_PACK_TENS;
         seg_q     <= SEG_RST;
         dig_q     <= 4'b1110;
      end else begin
         presc_q   <= presc_d;
         cork_q    <= cork_d;
         refills_q <= refills_d;
         state_q   <= state_d;
         lat_q     <= lat_d;
         busy_q    <= busy_d;
         starved_q <= starved_d;
         ovf_q     <= ovf_d;
         scan_q    <= scan_d;
         slot_q    <= slot_d;
         seg_q     <= seg_d;
         dig_q     <= dig_d;
      end
   end

   assign pack_bcd     = pack_val_s;
   assign cork_cnt     = cork_q;
   assign refills_left = refills_q;
   assign refill_busy  = busy_q;
   assign starved      = starved_q;
   assign pack_ovf     = ovf_q;
   assign seg          = seg_q;
   assign dig          = dig_q;

endmodule

// File: tb/tb_bottle_line_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bottle_line_ctrl
// Two controllers share one stimulus: u_dut0 with a 2-digit pack counter and
// u_dut1 with a 1-digit pack counter (reaches its wrap with the available
// corks, and blanks the pack-tens slot). Both use a 4-cycle scan slot.
// A behavioural model tracks bottles accepted, stock, credits and refill
// time remaining; every cycle all outputs of both DUTs are compared.
// ----------------------------------------------------------------------------
module tb_bottle_line_ctrl;

   localparam int P_BPP  = 12;
   localparam int P_MAX  = 25;
   localparam int P_LOW  = 5;
   localparam int P_AMT  = 20;
   localparam int P_CRED = 7;
   localparam int P_LAT  = 4;
   localparam int P_SCAN = 4;

   logic       clk;
   logic       rst_n;
   logic       bottle_pulse;
   logic [7:0] pack0;
   logic [3:0] pack1;
   logic [6:0] cork0, cork1, seg0, seg1;
   logic [2:0] ref0, ref1;
   logic       busy0, busy1, starved0, starved1, ovf0, ovf1;
   logic [3:0] dig0, dig1;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int         m_cork, m_credits, m_rem, m_accepted, m_cyc;
   bit         m_starved;
   logic [6:0] m_seg [2];
   logic [3:0] m_dig;

   bottle_line_ctrl #(
      .BOTTLES_PER_PACK (P_BPP), .PACK_DIGITS (2), .CORK_MAX (P_MAX),
      .CORK_LOW (P_LOW), .REFILL_AMT (P_AMT), .REFILL_CREDITS (P_CRED),
      .REFILL_LAT (P_LAT), .SCAN_DIV (P_SCAN)
   ) u_dut0 (
      .clk (clk), .rst_n (rst_n), .bottle_pulse (bottle_pulse),
      .pack_bcd (pack0), .cork_cnt (cork0), .refills_left (ref0),
      .refill_busy (busy0), .starved (starved0), .pack_ovf (ovf0),
      .seg (seg0), .dig (dig0)
   );

   bottle_line_ctrl #(
      .BOTTLES_PER_PACK (P_BPP), .PACK_DIGITS (1), .CORK_MAX (P_MAX),
      .CORK_LOW (P_LOW), .REFILL_AMT (P_AMT), .REFILL_CREDITS (P_CRED),
      .REFILL_LAT (P_LAT), .SCAN_DIV (P_SCAN)
   ) u_dut1 (
      .clk (clk), .rst_n (rst_n), .bottle_pulse (bottle_pulse),
      .pack_bcd (pack1), .cork_cnt (cork1), .refills_left (ref1),
      .refill_busy (busy1), .starved (starved1), .pack_ovf (ovf1),
      .seg (seg1), .dig (dig1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Plain 7-segment table (active-high gfedcba), inverted for the active-low pins.
   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] hi;
      case (d)
         0: hi = 7'h3F;  1: hi = 7'h06;  2: hi = 7'h5B;  3: hi = 7'h4F;
         4: hi = 7'h66;  5: hi = 7'h6D;  6: hi = 7'h7D;  7: hi = 7'h07;
         8: hi = 7'h7F;  9: hi = 7'h6F;
         default: hi = 7'h00;
      endcase
      return ~hi;
   endfunction

   function automatic int pack_val(input int digits);
      return (m_accepted / P_BPP) % ((digits == 1) ? 10 : 100);
   endfunction

   function automatic logic [6:0] exp_seg(input int digits, input int slot);
      int pv;
      pv = pack_val(digits);
      case (slot)
         0:       return (digits == 1) ? 7'h7F : seg_of(pv / 10);
         1:       return seg_of(pv % 10);
         2:       return seg_of(m_cork / 10);
         default: return seg_of(m_cork % 10);
      endcase
   endfunction

   task automatic model_reset();
      m_cork = P_MAX; m_credits = P_CRED; m_rem = 0; m_accepted = 0;
      m_cyc = 0; m_starved = 1'b0;
      m_seg[0] = seg_of(0); m_seg[1] = 7'h7F; m_dig = 4'b1110;
   endtask

   task automatic model_step(input bit p);
      int slot, acc, nxt;
      bit done;
      // Display registers capture the pre-edge slot and values.
      slot = (m_cyc / P_SCAN) % 4;
      m_seg[0] = exp_seg(2, slot);
      m_seg[1] = exp_seg(1, slot);
      m_dig = ~(4'b0001 << slot);
      m_cyc++;
      acc  = (p && m_cork > 0) ? 1 : 0;
      nxt  = m_cork - acc;
      done = 1'b0;
      if (m_rem > 0) begin
         if (m_rem == 1) begin
            nxt = (nxt + P_AMT > P_MAX) ? P_MAX : nxt + P_AMT;
            m_credits--;
            done = 1'b1;
         end
         m_rem--;
      end else if (m_cork <= P_LOW && m_credits > 0) begin
         m_rem = P_LAT;
      end
      if (p && m_cork == 0) m_starved = 1'b1;
      if (done) m_starved = 1'b0;
      m_cork = nxt;
      m_accepted += acc;
   endtask

   task automatic check_all();
      int pv0;
      pv0 = pack_val(2);
      chk("pack0", 32'(pack0), 32'((pv0 / 10) * 16 + pv0 % 10));
      chk("pack1", 32'(pack1), 32'(pack_val(1)));
      chk("ovf0", 32'(ovf0), (m_accepted >= P_BPP * 100) ? 32'd1 : 32'd0);
      chk("ovf1", 32'(ovf1), (m_accepted >= P_BPP * 10) ? 32'd1 : 32'd0);
      chk("cork0", 32'(cork0), 32'(m_cork));
      chk("cork1", 32'(cork1), 32'(m_cork));
      chk("refills0", 32'(ref0), 32'(m_credits));
      chk("refills1", 32'(ref1), 32'(m_credits));
      chk("busy0", 32'(busy0), (m_rem > 0) ? 32'd1 : 32'd0);
      chk("busy1", 32'(busy1), (m_rem > 0) ? 32'd1 : 32'd0);
      chk("starved0", 32'(starved0), 32'(m_starved));
      chk("starved1", 32'(starved1), 32'(m_starved));
      chk("seg0", 32'(seg0), 32'(m_seg[0]));
      chk("seg1", 32'(seg1), 32'(m_seg[1]));
      chk("dig0", 32'(dig0), 32'(m_dig));
      chk("dig1", 32'(dig1), 32'(m_dig));
   endtask

   task automatic step(input bit p);
      bottle_pulse = p;
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step(p);
      #1;
      check_all();
   endtask

   initial begin
      logic [3:0] dig_tab [4];
      dig_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      rst_n = 1'b0;
      bottle_pulse = 1'b0;

      // Reset values
      step(1'b0);
      step(1'b0);
      chk("rst_cork", 32'(cork0), 32'd25);
      chk("rst_refills", 32'(ref0), 32'd7);
      chk("rst_dig", 32'(dig0), 32'b1110);
      chk("rst_seg_blank_tens", 32'(seg1), 32'h7F);
      rst_n = 1'b1;

      // One pack, then drain to the low mark
      repeat (12) step(1'b1);
      chk("pack_after_12", 32'(pack0), 32'h01);
      chk("cork_after_12", 32'(cork0), 32'd13);
      chk("no_refill_yet", 32'(busy0), 32'd0);
      repeat (8) step(1'b1);
      chk("cork_at_low", 32'(cork0), 32'd5);
      step(1'b0);
      chk("busy_rises", 32'(busy0), 32'd1);

      // Refill with no bottles: stock lands exactly REFILL_LAT cycles later
      repeat (3) step(1'b0);
      chk("cork_during_refill", 32'(cork0), 32'd5);
      step(1'b0);
      chk("cork_refilled", 32'(cork0), 32'd25);
      chk("credits_6", 32'(ref0), 32'd6);

      // Bottle on the final refill cycle is netted out
      repeat (20) step(1'b1);
      step(1'b0);
      repeat (3) step(1'b0);
      step(1'b1);
      chk("cork_net_refill", 32'(cork0), 32'd24);
      chk("credits_5", 32'(ref0), 32'd5);
      chk("pack_after_41", 32'(pack0), 32'h03);

      // Random traffic until every credit is used
      for (int i = 0; i < 3000 && !(m_credits == 0 && m_rem == 0); i++)
         step($urandom_range(99, 0) < 60);
      chk("credits_exhausted", 32'(ref0), 32'd0);

      // Drain to empty, then a rejected bottle
      for (int i = 0; i < 200 && m_cork > 0; i++) step(1'b1);
      chk("cork_empty", 32'(cork0), 32'd0);
      step(1'b1);
      step(1'b0);
      chk("starved_set", 32'(starved0), 32'd1);
      chk("cork_stays_empty", 32'(cork0), 32'd0);
      chk("idle_without_credits", 32'(busy0), 32'd0);
      // 165 corks in total -> 13 packs; the 1-digit counter wrapped once
      chk("pack_total", 32'(pack0), 32'h13);
      chk("pack1_wrapped", 32'(pack1), 32'h3);
      chk("ovf1_set", 32'(ovf1), 32'd1);
      chk("ovf0_clear", 32'(ovf0), 32'd0);

      // Reset in the middle of a refill
      rst_n = 1'b0;
      step(1'b0);
      rst_n = 1'b1;
      repeat (20) step(1'b1);
      step(1'b0);
      chk("busy_before_abort", 32'(busy0), 32'd1);
      step(1'b0);
      rst_n = 1'b0;
      step(1'b0);
      chk("abort_busy", 32'(busy0), 32'd0);
      chk("abort_cork", 32'(cork0), 32'd25);
      chk("abort_credits", 32'(ref0), 32'd7);
      chk("abort_pack", 32'(pack0), 32'h00);
      chk("abort_starved", 32'(starved0), 32'd0);
      rst_n = 1'b1;

      // Digit scan sequence after reset
      for (int k = 1; k <= 16; k++) begin
         step(1'b0);
         chk("dig_seq", 32'(dig0), 32'(dig_tab[(k - 1) / 4]));
      end
      bottle_pulse = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
